// File: rtl/waveform_gen_arbiter.sv
// waveform_gen_arbiter
//   Shares one waveform_gen among NUM_REQ requesters. Requesters are picked
//   round-robin. Each granted burst runs a fixed sequence:
//   warm-up (enable only), drive (enable + sig_in for len cycles),
//   gap (enable only), then a one-cycle done pulse to the owner.
//
// Ports
//   clk         system clock, rising-edge active
//   rst_n       asynchronous active-low reset
//   req         per-requester level request
//   len         packed burst lengths, requester i at len[i*LEN_W +: LEN_W]
//   grant       one-hot owner of the generator, zero when idle
//   done        one-cycle completion pulse for the served requester
//   busy        high whenever a burst is in progress
//   gen_enable  drives waveform_gen.enable
//   gen_sig_in  drives waveform_gen.sig_in
module waveform_gen_arbiter #(
    parameter int NUM_REQ       = 4,
    parameter int LEN_W         = 4,
    parameter int WARMUP_CYCLES = 2,
    parameter int GAP_CYCLES    = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_REQ-1:0]       req,
    input  logic [NUM_REQ*LEN_W-1:0] len,
    output logic [NUM_REQ-1:0]       grant,
    output logic [NUM_REQ-1:0]       done,
    output logic                     busy,
    output logic                     gen_enable,
    output logic                     gen_sig_in
);

    localparam int IDX_W  = $clog2(NUM_REQ);
    localparam int PH_MAX = (WARMUP_CYCLES > GAP_CYCLES) ? WARMUP_CYCLES : GAP_CYCLES;
    localparam int PH_W   = $clog2(PH_MAX + 1);
    localparam int CNT_W  = ((LEN_W > PH_W) ? LEN_W : PH_W) + 1;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_WARMUP = 3'd1;
    localparam logic [2:0] ST_DRIVE  = 3'd2;
    localparam logic [2:0] ST_GAP    = 3'd3;
    localparam logic [2:0] ST_DONE   = 3'd4;

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [IDX_W-1:0] IDX_ONE = IDX_W'(1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_REQ - 1);

    logic [2:0]         state_reg, state_next;
    logic [CNT_W-1:0]   cnt_reg, cnt_next, cnt_inc;
    logic [LEN_W-1:0]   len_reg, len_next;
    logic [IDX_W-1:0]   owner_reg, owner_next;
    logic [IDX_W-1:0]   ptr_reg, ptr_next;
    logic [NUM_REQ-1:0] grant_next, done_next;
    logic               busy_next, enable_next, sig_next;

    logic [LEN_W-1:0]   len_arr [NUM_REQ];
    logic               win_found;
    logic [IDX_W-1:0]   win_idx;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_len
            assign len_arr[gi] = len[gi*LEN_W +: LEN_W];
        end
    endgenerate

    // Round-robin search: first requester at or after the pointer, wrapping.
    always_comb begin
        int idx;
        idx       = 0;
        win_found = 1'b0;
        win_idx   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = int'(ptr_reg) + k;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            if (!win_found && req[idx]) begin
                win_found = 1'b1;
                win_idx   = IDX_W'(idx);
            end
        end
    end

    assign cnt_inc = cnt_reg + CNT_ONE;

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        len_next   = len_reg;
        owner_next = owner_reg;
        ptr_next   = ptr_reg;
        grant_next = grant;
        case (state_reg)
            ST_IDLE: begin
                if (win_found) begin
                    state_next = ST_WARMUP;
                    cnt_next   = '0;
                    len_next   = len_arr[win_idx];
                    owner_next = win_idx;
                    grant_next = NUM_REQ'(1) << win_idx;
                end
            end
            ST_WARMUP: begin
                if (cnt_inc == CNT_W'(WARMUP_CYCLES)) begin
                    cnt_next   = '0;
                    // A zero-length burst skips DRIVE entirely.
                    state_next = (len_reg != '0) ? ST_DRIVE : ST_GAP;
                end else begin
                    cnt_next = cnt_inc;
                end
            end
            ST_DRIVE: begin
                if (cnt_inc == CNT_W'(len_reg)) begin
                    cnt_next   = '0;
                    state_next = ST_GAP;
                end else begin
                    cnt_next = cnt_inc;
                end
            end
            ST_GAP: begin
                if (cnt_inc == CNT_W'(GAP_CYCLES)) begin
                    cnt_next   = '0;
                    state_next = ST_DONE;
                end else begin
                    cnt_next = cnt_inc;
                end
            end
            ST_DONE: begin
                state_next = ST_IDLE;
                grant_next = '0;
                ptr_next   = (owner_reg == IDX_LAST) ? '0 : owner_reg + IDX_ONE;
            end
            default: begin
                state_next = ST_IDLE;
                grant_next = '0;
            end
        endcase
    end

    // Outputs are decoded from the next state and registered, so each output
    // reflects the state being entered on the same edge.
    always_comb begin
        busy_next   = (state_next != ST_IDLE);
        enable_next = (state_next == ST_WARMUP) || (state_next == ST_DRIVE) ||
                      (state_next == ST_GAP);
        sig_next    = (state_next == ST_DRIVE);
        done_next   = (state_next == ST_DONE) ? grant_next : '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg  <= ST_IDLE;
            cnt_reg    <= '0;
            len_reg    <= '0;
            owner_reg  <= '0;
            ptr_reg    <= '0;
            grant      <= '0;
            done       <= '0;
            busy       <= 1'b0;
            gen_enable <= 1'b0;
            gen_sig_in <= 1'b0;
        end else begin
            state_reg  <= state_next;
            cnt_reg    <= cnt_next;
            len_reg    <= len_next;
            owner_reg  <= owner_next;
            ptr_reg    <= ptr_next;
            grant      <= grant_next;
            done       <= done_next;
            busy       <= busy_next;
            gen_enable <= enable_next;
            gen_sig_in <= sig_next;
        end
    end

endmodule

// File: tb/tb_waveform_gen_arbiter.sv
module tb_waveform_gen_arbiter;

    localparam int N  = 4;
    localparam int LW = 4;
    localparam int W  = 2;
    localparam int G  = 2;

    logic          clk   = 1'b0;
    logic          rst_n = 1'b0;
    logic [N-1:0]  req   = '0;
    logic [N*LW-1:0] len = '0;
    logic [N-1:0]  grant, done;
    logic          busy, gen_enable, gen_sig_in;

    int n_tests = 0;
    int n_fail  = 0;

    waveform_gen_arbiter #(
        .NUM_REQ(N), .LEN_W(LW), .WARMUP_CYCLES(W), .GAP_CYCLES(G)
    ) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .len(len),
        .grant(grant), .done(done), .busy(busy),
        .gen_enable(gen_enable), .gen_sig_in(gen_sig_in)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Timeline model: a burst granted at edge E with length L occupies
    // t = 0 .. W+L+G (t counts cycles since E); the following cycle is idle.
    int m_active = 0, m_t = 0, m_owner = 0, m_len = 0, m_ptr = 0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_active = 0; m_t = 0; m_owner = 0; m_len = 0; m_ptr = 0;
        end else if (m_active != 0) begin
            m_t++;
            if (m_t > W + m_len + G) begin
                m_active = 0;
                m_ptr    = (m_owner + 1) % N;
            end
        end else begin
            for (int k = 0; k < N; k++) begin
                int idx;
                idx = (m_ptr + k) % N;
                if (m_active == 0 && req[idx]) begin
                    m_active = 1;
                    m_t      = 0;
                    m_owner  = idx;
                    m_len    = int'(len[idx*LW +: LW]);
                end
            end
        end
    end

    always @(negedge clk) begin
        logic [N-1:0] e_grant, e_done;
        logic e_en, e_sig, e_busy;
        e_grant = (m_active != 0) ? (N'(1) << m_owner) : '0;
        e_busy  = (m_active != 0);
        e_en    = (m_active != 0) && (m_t < W + m_len + G);
        e_sig   = (m_active != 0) && (m_t >= W) && (m_t < W + m_len);
        e_done  = ((m_active != 0) && (m_t == W + m_len + G)) ? e_grant : '0;
        check("grant", 32'(grant), 32'(e_grant));
        check("done", 32'(done), 32'(e_done));
        check("busy", 32'(busy), 32'(e_busy));
        check("gen_enable", 32'(gen_enable), 32'(e_en));
        check("gen_sig_in", 32'(gen_sig_in), 32'(e_sig));
        if (done != '0) $display("[TB] burst complete done=%b at %0t", done, $time);
    end

    // Window statistics, cycles numbered from 1 = first cycle after grant edge.
    int w_grant_cnt, w_en_cnt, w_sig_cnt, w_sig_first, w_sig_last, w_done_cycle;
    logic [N-1:0] w_done_val, w_grant_val;

    task automatic run_window(input int n, input logic [N*LW-1:0] new_len);
        w_grant_cnt = 0; w_en_cnt = 0; w_sig_cnt = 0;
        w_sig_first = 0; w_sig_last = 0; w_done_cycle = 0;
        w_done_val = '0; w_grant_val = '0;
        for (int i = 1; i <= n; i++) begin
            @(negedge clk);
            if (i == 1) begin
                w_grant_val = grant;
                req = '0;
                len = new_len;
            end
            if (grant != '0) w_grant_cnt++;
            if (gen_enable) w_en_cnt++;
            if (gen_sig_in) begin
                w_sig_cnt++;
                if (w_sig_first == 0) w_sig_first = i;
                w_sig_last = i;
            end
            if (done != '0) begin
                w_done_cycle = i;
                w_done_val   = done;
            end
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        logic [N-1:0] gseq [8];
        int gaps [8];
        int gcount, idle_len;
        logic prev_busy;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_grant", 32'(grant), 0);
        check("rst_outs", {29'd0, busy, gen_enable, gen_sig_in}, 0);
        rst_n = 1'b1;

        // Single burst, len0 = 3
        len = 16'h0003;
        req = 4'b0001;
        run_window(10, 16'h0003);
        $display("[TB] single burst grant=%b done_cycle=%0d", w_grant_val, w_done_cycle);
        check("t1_grant_val", 32'(w_grant_val), 32'h1);
        check("t1_grant_cnt", w_grant_cnt, 8);
        check("t1_en_cnt", w_en_cnt, 7);
        check("t1_sig_first", w_sig_first, 3);
        check("t1_sig_last", w_sig_last, 5);
        check("t1_done_cycle", w_done_cycle, 8);
        check("t1_done_val", 32'(w_done_val), 32'h1);

        // Round-robin fairness from pointer 0
        do_reset();
        len = 16'h1111;
        req = 4'b1111;
        gcount = 0; idle_len = 0; prev_busy = 1'b0;
        for (int i = 0; i < 8; i++) begin gseq[i] = '0; gaps[i] = 0; end
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (busy && !prev_busy) begin
                if (gcount > 0 && gcount < 8) gaps[gcount-1] = idle_len;
                if (gcount < 8) gseq[gcount] = grant;
                gcount++;
                $display("[TB] rr grant %0d = %b", gcount, grant);
                if (gcount == 5) req = '0;
            end
            idle_len  = busy ? 0 : idle_len + 1;
            prev_busy = busy;
        end
        check("t2_count", gcount, 5);
        check("t2_g0", 32'(gseq[0]), 32'h1);
        check("t2_g1", 32'(gseq[1]), 32'h2);
        check("t2_g2", 32'(gseq[2]), 32'h4);
        check("t2_g3", 32'(gseq[3]), 32'h8);
        check("t2_g4", 32'(gseq[4]), 32'h1);
        for (int i = 0; i < 4; i++) check("t2_gap", gaps[i], 1);

        // Zero length
        len = 16'h0000;
        req = 4'b0100;
        run_window(8, 16'h0000);
        $display("[TB] zero-length grant=%b done_cycle=%0d", w_grant_val, w_done_cycle);
        check("t3_grant_val", 32'(w_grant_val), 32'h4);
        check("t3_sig_cnt", w_sig_cnt, 0);
        check("t3_en_cnt", w_en_cnt, 4);
        check("t3_done_cycle", w_done_cycle, 5);
        check("t3_done_val", 32'(w_done_val), 32'h4);

        // Max length, request withdrawn and len changed after grant
        len = 16'h00F0;
        req = 4'b0010;
        run_window(24, 16'h0000);
        $display("[TB] max-length grant=%b done_cycle=%0d", w_grant_val, w_done_cycle);
        check("t4_grant_val", 32'(w_grant_val), 32'h2);
        check("t4_sig_cnt", w_sig_cnt, 15);
        check("t4_sig_first", w_sig_first, 3);
        check("t4_done_cycle", w_done_cycle, 20);
        check("t4_done_val", 32'(w_done_val), 32'h2);

        // Reset mid-burst
        len = 16'h0050;
        req = 4'b0010;
        repeat (4) @(negedge clk);
        check("t5_in_drive", 32'(gen_sig_in), 1);
        #2;
        rst_n = 1'b0;
        req = 4'b0011;
        #1;
        check("t5_async_en", 32'(gen_enable), 0);
        check("t5_async_sig", 32'(gen_sig_in), 0);
        check("t5_async_grant", 32'(grant), 0);
        check("t5_async_done", 32'(done), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        $display("[TB] after reset grant=%b", grant);
        check("t5_winner", 32'(grant), 32'h1);
        req = '0;
        repeat (12) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
